// File: rtl/act_skew_feeder_pkg.sv
// act_skew_feeder_pkg: shared sizes, SRAM latency and FSM encoding for the activation skew feeder
package act_skew_feeder_pkg;
  localparam int ROWS = 32;
  localparam int DW = 4;
  localparam int AW = 15;
  localparam int RD_LAT = 1;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;
  function automatic int drain_cycles(input int rows);
    return RD_LAT + rows - 1;
  endfunction
endpackage

// File: rtl/act_skew_feeder_if.sv
// act_skew_feeder_if: tile control, SRAM read port and compute-core activation bus
interface act_skew_feeder_if #(
  parameter int ROWS = act_skew_feeder_pkg::ROWS,
  parameter int DW = act_skew_feeder_pkg::DW,
  parameter int AW = act_skew_feeder_pkg::AW
);
  logic start;
  logic [AW-1:0] base_addr;
  logic [7:0] tile_len;
  logic bce;
  logic [AW-1:0] braddr;
  logic brvalid;
  logic [ROWS*DW-1:0] brdata;
  logic [ROWS*DW-1:0] act_data_out;
  logic act_pe_valid;
  logic start_calc;
  logic pingpang;
  logic busy;
  logic done;
  modport master (
    output start, base_addr, tile_len, brvalid, brdata,
    input bce, braddr, act_data_out, act_pe_valid, start_calc, pingpang, busy, done
  );
  modport slave (
    input start, base_addr, tile_len, brvalid, brdata,
    output bce, braddr, act_data_out, act_pe_valid, start_calc, pingpang, busy, done
  );
endinterface

// File: rtl/act_skew_feeder_skew_line.sv
// act_skew_feeder_skew_line: DEPTH-cycle delay line for one activation lane (DEPTH=0 is a wire)
module act_skew_feeder_skew_line #(
  parameter int DEPTH = 0,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst_n};
      assign q = d;
    end else begin : g_reg
      logic [DW-1:0] sr [DEPTH];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          for (int j = 0; j < DEPTH; j++) sr[j] <= '0;
        end else begin
          sr[0] <= d;
          for (int j = 1; j < DEPTH; j++) sr[j] <= sr[j-1];
        end
      assign q = sr[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/act_skew_feeder.sv
// act_skew_feeder: streams a tile of activation words from SRAM and skews lane i by i cycles
module act_skew_feeder #(
  parameter int ROWS = act_skew_feeder_pkg::ROWS,
  parameter int DW = act_skew_feeder_pkg::DW,
  parameter int AW = act_skew_feeder_pkg::AW
) (
  input logic clk,
  input logic rst_n,
  act_skew_feeder_if.slave bus
);
  import act_skew_feeder_pkg::*;
  localparam int DRAIN_LEN = drain_cycles(ROWS);
  state_t state, nxt;
  logic [7:0] len, cnt;
  logic [15:0] dcnt;
  logic [AW-1:0] addr;
  logic accept, zero_req, last_rd, drain_end, done_r, pp;
  logic [ROWS*DW-1:0] act;
  assign accept = state == IDLE && bus.start && bus.tile_len != 8'd0;
  assign zero_req = state == IDLE && bus.start && bus.tile_len == 8'd0;
  assign last_rd = state == READ && cnt == len - 8'd1;
  assign drain_end = state == DRAIN && dcnt == 16'(DRAIN_LEN - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // each transition condition already implies its source state; unused encodings fall back to IDLE
  always_comb
    nxt = accept ? READ :
          last_rd ? DRAIN :
          drain_end ? IDLE :
          (state == READ || state == DRAIN) ? state : IDLE;
  always_comb begin
    bus.bce = state == READ;
    bus.start_calc = accept;
    bus.busy = state != IDLE;
  end
  // the address stops on the last word so braddr holds it after the read phase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len <= '0;
      cnt <= '0;
      addr <= '0;
      dcnt <= '0;
      done_r <= 1'b0;
      pp <= 1'b0;
    end else begin
      if (accept) begin
        addr <= bus.base_addr;
        len <= bus.tile_len;
        cnt <= '0;
      end else if (state == READ) begin
        cnt <= cnt + 8'd1;
        if (!last_rd) addr <= addr + AW'(1);
      end
      dcnt <= state == DRAIN ? dcnt + 16'd1 : '0;
      done_r <= zero_req || drain_end;
      if (drain_end) pp <= ~pp;
    end
  assign bus.braddr = addr;
  assign bus.done = done_r;
  assign bus.pingpang = pp;
  assign bus.act_pe_valid = bus.brvalid;
  assign bus.act_data_out = act;
  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    act_skew_feeder_skew_line #(.DEPTH(i), .DW(DW)) u_line (
      .clk(clk),
      .rst_n(rst_n),
      .d(bus.brvalid ? bus.brdata[i*DW +: DW] : '0),
      .q(act[i*DW +: DW])
    );
  end
endmodule

// File: tb/tb_act_skew_feeder.sv
// tb_act_skew_feeder: tile-level model of the skew feeder checked every cycle, plus directed literal checks
module tb_act_skew_feeder;
  localparam int ROWS = act_skew_feeder_pkg::ROWS;
  localparam int DW = act_skew_feeder_pkg::DW;
  localparam int AW = act_skew_feeder_pkg::AW;
  localparam int W = ROWS * DW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  act_skew_feeder_if #(.ROWS(ROWS), .DW(DW), .AW(AW)) bus ();
  act_skew_feeder #(.ROWS(ROWS), .DW(DW), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int cyc = 0;
  int total = 0;
  int bad = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // SRAM word: lane i = 3*addr[3:0] + i, so words at xxx0 carry lane i = i
  function automatic logic [W-1:0] word(input logic [AW-1:0] a);
    logic [W-1:0] w;
    for (int i = 0; i < ROWS; i++) w[i*DW +: DW] = DW'(int'(a[3:0]) * 3 + i);
    return w;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.brvalid <= 1'b0;
      bus.brdata <= '0;
    end else begin
      bus.brvalid <= bus.bce;
      bus.brdata <= bus.bce ? word(bus.braddr) : W'({$urandom(), $urandom(), $urandom(), $urandom()});
    end
  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", nm, cyc, got, exp);
    end
  endtask
  bit have, have_z, pp;
  int s, n, z, c, k;
  logic [AW-1:0] base, ea;
  logic e_bce, e_sc, e_busy, e_done, e_v;
  logic [W-1:0] e_act, wv;
  always @(negedge clk) begin
    if (!rst_n) begin
      have = 0; have_z = 0; pp = 0; ea = '0;
      e_bce = 0; e_sc = 0; e_busy = 0; e_done = 0; e_v = 0; e_act = '0;
    end else begin
      c = cyc;
      e_done = (have && c == s + n + 33) || (have_z && c == z + 1);
      if (have && c == s + n + 33) pp = ~pp;
      if (bus.start && !(have && c <= s + n + 32)) begin
        if (bus.tile_len != 8'd0) begin
          have = 1; s = c; n = int'(bus.tile_len); base = bus.base_addr;
        end else begin
          have_z = 1; z = c;
        end
      end
      e_bce = have && c >= s + 1 && c <= s + n;
      if (e_bce) ea = base + AW'(c - s - 1);
      e_sc = have && c == s;
      e_busy = have && c >= s + 1 && c <= s + n + 32;
      e_v = have && c >= s + 2 && c <= s + n + 1;
      for (int i = 0; i < ROWS; i++) begin
        k = c - s - 2 - i;
        wv = word(base + AW'(k));
        e_act[i*DW +: DW] = (have && k >= 0 && k < n) ? wv[i*DW +: DW] : '0;
      end
    end
    chk("bce", W'(bus.bce), W'(e_bce));
    chk("braddr", W'(bus.braddr), W'(ea));
    chk("start_calc", W'(bus.start_calc), W'(e_sc));
    chk("busy", W'(bus.busy), W'(e_busy));
    chk("done", W'(bus.done), W'(e_done));
    chk("pingpang", W'(bus.pingpang), W'(pp));
    chk("act_pe_valid", W'(bus.act_pe_valid), W'(e_v));
    chk("act_data_out", bus.act_data_out, e_act);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [AW-1:0] a, input logic [7:0] l);
    bus.start = 1'b1;
    bus.base_addr = a;
    bus.tile_len = l;
  endtask
  task automatic wait_done(input int s0, input int delta, input string nm);
    int t = 0;
    while (!bus.done && t < 200) begin
      tick();
      t++;
    end
    chk(nm, W'(cyc - s0), W'(delta));
  endtask
  int s0;
  initial begin
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.tile_len = '0;
    repeat (3) tick();
    chk("rst_bce", W'(bus.bce), W'(0));
    chk("rst_braddr", W'(bus.braddr), W'(0));
    chk("rst_pingpang", W'(bus.pingpang), W'(0));
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_valid", W'(bus.act_pe_valid), W'(0));
    rst_n = 1'b1;
    tick();
    go(15'h0100, 8'd4); s0 = cyc; #1;
    chk("t1_start_calc", W'(bus.start_calc), W'(1));
    tick(); bus.start = 1'b0;
    chk("t1_bce_c1", W'(bus.bce), W'(1));
    chk("t1_addr_c1", W'(bus.braddr), W'(15'h0100));
    tick();
    chk("t1_valid_c2", W'(bus.act_pe_valid), W'(1));
    chk("t1_addr_c2", W'(bus.braddr), W'(15'h0101));
    tick(); tick();
    chk("t1_addr_c4", W'(bus.braddr), W'(15'h0103));
    tick();
    chk("t1_bce_c5", W'(bus.bce), W'(0));
    chk("t1_valid_c5", W'(bus.act_pe_valid), W'(1));
    tick();
    chk("t1_valid_c6", W'(bus.act_pe_valid), W'(0));
    wait_done(s0, 37, "t1_done_cycle");
    chk("t1_pingpang", W'(bus.pingpang), W'(1));
    tick();
    chk("t1_done_pulse", W'(bus.done), W'(0));
    go(15'h0200, 8'd1); s0 = cyc;
    tick(); bus.start = 1'b0;
    repeat (6) tick();
    chk("t2_lane5_c7", W'(bus.act_data_out[5*DW +: DW]), W'(5));
    chk("t2_lane4_c7", W'(bus.act_data_out[4*DW +: DW]), W'(0));
    tick();
    chk("t2_lane5_c8", W'(bus.act_data_out[5*DW +: DW]), W'(0));
    chk("t2_lane6_c8", W'(bus.act_data_out[6*DW +: DW]), W'(6));
    wait_done(s0, 34, "t2_done_cycle");
    chk("t2_pingpang", W'(bus.pingpang), W'(0));
    go(15'h0300, 8'd4); s0 = cyc;
    tick(); bus.start = 1'b0;
    tick();
    go(15'h0555, 8'd9); #1;
    chk("t3_ignored_start", W'(bus.start_calc), W'(0));
    tick(); bus.start = 1'b0;
    tick();
    chk("t3_addr_c4", W'(bus.braddr), W'(15'h0303));
    wait_done(s0, 37, "t3_done_cycle");
    chk("t3_addr_hold", W'(bus.braddr), W'(15'h0303));
    chk("t3_pingpang", W'(bus.pingpang), W'(1));
    go(15'h0400, 8'd0);
    tick(); bus.start = 1'b0;
    chk("t4_done", W'(bus.done), W'(1));
    chk("t4_bce", W'(bus.bce), W'(0));
    chk("t4_pingpang", W'(bus.pingpang), W'(1));
    tick();
    chk("t4_done_pulse", W'(bus.done), W'(0));
    go(15'h7FFE, 8'd3);
    tick(); bus.start = 1'b0;
    chk("t5_addr0", W'(bus.braddr), W'(15'h7FFE));
    tick();
    chk("t5_addr1", W'(bus.braddr), W'(15'h7FFF));
    tick();
    chk("t5_addr2", W'(bus.braddr), W'(15'h0000));
    chk("t5_busy", W'(bus.busy), W'(1));
    rst_n = 1'b0; #1;
    chk("t5_rst_bce", W'(bus.bce), W'(0));
    chk("t5_rst_busy", W'(bus.busy), W'(0));
    chk("t5_rst_pingpang", W'(bus.pingpang), W'(0));
    chk("t5_rst_act", bus.act_data_out, '0);
    repeat (3) tick();
    chk("t5_rst_done", W'(bus.done), W'(0));
    rst_n = 1'b1;
    tick();
    go(15'h0010, 8'd2); s0 = cyc;
    tick(); bus.start = 1'b0;
    wait_done(s0, 35, "t6_done_cycle");
    chk("t6_pingpang", W'(bus.pingpang), W'(1));
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
